// File: rtl/ring_arb_pkg.sv
// Shared types and defaults for the ring round-robin arbiter.
// State enum plus default N / MAX_HOLD values.
package ring_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/ring_token.sv
// One-hot ring token holding the current priority position.
// Ports: clk, rst (sync active-low), adv strobe, winner index, token out.
import ring_arb_pkg::*;

module ring_token #(
  parameter int N  = N_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic [IW-1:0] winner,
  output logic [N-1:0]  token
);

  logic [N-1:0] token_q;
  logic [N-1:0] token_d;
  int           nxt;

  // Last winner becomes lowest priority: token moves one past it.
  always_comb begin
    token_d = token_q;
    nxt     = (int'(winner) + 1) % N;
    if (adv) begin
      token_d = N'(1) << nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      token_q <= N'(1);
    end else begin
      token_q <= token_d;
    end
  end

  assign token = token_q;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with one-hot ring token and registered grant.
// Ports: clk, rst (sync active-low), req[N], done -> grant[N],
// grant_id, busy, timeout. RING_ARB_TIMEOUT_EN enables the hold timeout.
import ring_arb_pkg::*;

module ring_rr_arbiter #(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  if (N < 2 || MAX_HOLD < 2) begin : g_bad_param
    $error("ring_rr_arbiter: N and MAX_HOLD must be >= 2");
  end

  state_e        state_q;
  state_e        state_d;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  grant_d;
  logic [IW-1:0] grant_id_q;
  logic [IW-1:0] grant_id_d;
  logic          busy_q;
  logic          busy_d;

  logic [N-1:0]  token;
  logic [N-1:0]  others;
  logic [IW-1:0] win;
  logic          new_gnt;
  logic          rel;
  logic          expire;
  int unsigned   tok_idx;

  // First set bit of m at or above s, wrapping past N-1.
  // Walking downward lets the nearest candidate overwrite farther ones.
  function automatic logic [IW-1:0] pick(
    input logic [N-1:0] m,
    input int unsigned  s
  );
    int unsigned idx;
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (s + i) % N;
      if (m[idx]) pick = IW'(idx);
    end
  endfunction

  ring_token #(
    .N  (N),
    .IW (IW)
  ) u_token (
    .clk    (clk),
    .rst    (rst),
    .adv    (new_gnt),
    .winner (win),
    .token  (token)
  );

  always_comb begin
    tok_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (token[i]) tok_idx = i;
    end
  end

  assign rel    = (state_q == GRANT) && (done || !req[grant_id_q]);
  assign others = req & ~grant_q;

`ifdef RING_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          timeout_q;
  logic          timeout_d;

  // A release on the expiry edge wins, so no pulse then.
  assign expire = (state_q == GRANT) && !rel &&
                  (hold_q == HW'(MAX_HOLD - 1));

  always_comb begin
    timeout_d = expire;
    if (new_gnt || state_d == IDLE) begin
      hold_d = '0;
    end else begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    new_gnt    = 1'b0;
    win        = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          new_gnt = 1'b1;
          win     = pick(req, tok_idx);
        end
      end
      GRANT: begin
        if (rel || expire) begin
          // Owner is excluded from this one re-pick.
          if (|others) begin
            new_gnt = 1'b1;
            win     = pick(others, tok_idx);
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end
      end
    endcase
    if (new_gnt) begin
      state_d    = GRANT;
      grant_d    = N'(1) << win;
      grant_id_d = win;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed self-checking bench for ring_rr_arbiter (N=4).
// Define RING_ARB_TIMEOUT_EN to also exercise the hold timeout.
module tb_ring_rr_arbiter;

  localparam int N = 4;
`ifdef RING_ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout;

  int checks;
  int failures;

  ring_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_g(
    input string      tag,
    input logic [3:0] g,
    input logic [1:0] id,
    input logic       b
  );
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".id"}, 32'(grant_id), 32'(id));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [3:0] exp_g;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    req      = '0;
    done     = 1'b0;

    tick();
    tick();
    chk_g("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.timeout", 32'(timeout), 32'd0);
    rst = 1'b1;

    // single request, release to idle; grant_id holds
    req = 4'b0100;
    tick();
    chk_g("single", 4'b0100, 2'd2, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    chk_g("single.rel", 4'b0000, 2'd2, 1'b0);
    tick();

    // token is at bit 3 here; reset must bring it back to bit 0
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      chk_g($sformatf("fair%0d", k), exp_g, 2'(k % 4), 1'b1);
      tick();
      chk_g($sformatf("fair%0d.hold", k), exp_g, 2'(k % 4), 1'b1);
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    chk_g("fair.next", 4'b0010, 2'd1, 1'b1);

    // token wrap: grant 3 moves token to bit 0
    do_reset();
    req = 4'b1000;
    tick();
    chk_g("wrap.g3", 4'b1000, 2'd3, 1'b1);
    req = '0;
    tick();
    chk_g("wrap.idle", 4'b0000, 2'd3, 1'b0);
    req = 4'b1010;
    tick();
    chk_g("wrap.g1", 4'b0010, 2'd1, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_g("wrap.g3b", 4'b1000, 2'd3, 1'b1);

    // request drop as release; token at bit 2 after grant 1
    req = '0;
    tick();
    req = 4'b0010;
    tick();
    chk_g("drop.g1", 4'b0010, 2'd1, 1'b1);
    req = 4'b1011;
    tick();
    chk_g("drop.hold", 4'b0010, 2'd1, 1'b1);
    req = 4'b0101;
    tick();
    chk_g("drop.g2", 4'b0100, 2'd2, 1'b1);

    // reset mid-grant
    req = 4'b1000;
    tick();
    chk_g("mid.g3", 4'b1000, 2'd3, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_g("mid.rst", 4'b0000, 2'd0, 1'b0);
    chk("mid.timeout", 32'(timeout), 32'd0);
    req = 4'b1001;
    tick();
    chk_g("mid.g0", 4'b0001, 2'd0, 1'b1);

`ifdef RING_ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_g($sformatf("to.hold%0d", c), 4'b0001, 2'd0, 1'b1);
      chk($sformatf("to.nopulse%0d", c), 32'(timeout), 32'd0);
    end
    tick();
    chk_g("to.revoke", 4'b0010, 2'd1, 1'b1);
    chk("to.pulse", 32'(timeout), 32'd1);
    tick();
    tick();
    tick();
    chk("to.pulse1cyc", 32'(timeout), 32'd0);
    chk_g("to.held", 4'b0010, 2'd1, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_g("to.rel", 4'b0001, 2'd0, 1'b1);
    chk("to.relnopulse", 32'(timeout), 32'd0);
`else
    // without the timeout, a grant is held indefinitely
    do_reset();
    req = 4'b0011;
    tick();
    for (int c = 0; c < 20; c++) tick();
    chk_g("notimeout.hold", 4'b0001, 2'd0, 1'b1);
    chk("notimeout.pulse", 32'(timeout), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
